seven_seg_scan_driver: RTL
==========================

Name: seven_seg_scan_driver

Overview:
Time-multiplexed scan controller for a NUM_DIGITS common-anode 7-segment display. It holds a hex value, steps through the digits at a programmable refresh rate, and presents one 4-bit nibble per slot on digit_out. digit_out feeds the team's hex-to-active-low-segment decoder, and the block drives active-low anode enables and the decimal point directly. Value updates are double-buffered and take effect only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clk cycles per digit slot (>=2)
DIV_W, 16, prescaler width; must satisfy 2**DIV_W >= REFRESH_DIV

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan running; 0 = display dark
load  in  1  single-cycle strobe; capture value/dp_in into pending buffer
value  in  4*NUM_DIGITS  hex digits; nibble i (bits 4i+3:4i) = digit i, digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_lz  in  1  1 = suppress leading zeros
digit_out  out  4  nibble for currently selected digit, to segment decoder
an  out  NUM_DIGITS  anode enables, active low, at most one bit low
dp_out  out  1  decimal point, active low
frame_tick  out  1  one-cycle pulse when scan wraps to digit 0
pending  out  1  1 = loaded value not yet applied

Behaviour:
- Reset (async, rst_n=0): an all 1, digit_out=0, dp_out=1, frame_tick=0, pending=0, display/dp registers 0, prescaler=0, idx=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. slot_end asserts when the count equals REFRESH_DIV-1.
- On slot_end, idx goes to idx+1, or to 0 when idx=NUM_DIGITS-1. The wrap to 0 marks a frame boundary.
- Frame boundary:
  - frame_tick=1 for exactly one cycle, in the cycle after the wrap edge (registered).
  - If pending=1, the display/dp registers take the pending buffer on that same edge, and pending clears.
- Load:
  - load=1 captures value and dp_in into the pending buffer and sets pending.
  - A repeated load before the boundary overwrites the buffer (last load wins).
  - load coincident with a boundary transfer: the old buffer transfers. The new data is captured into the buffer and pending stays 1.
- Outputs are registered and reflect the idx value one cycle after idx changes (latency 1).
  - digit_out = display nibble[idx]; dp_out = ~dp[idx]; an = ~(1<<idx) unless the digit is blanked.
- Leading-zero blanking: digit i (i>0) is blanked when blank_lz=1 and every nibble j>=i is 0. Digit 0 is never blanked.
  - Blanked digit: an all 1 for that slot, dp_out=1. digit_out still shows the nibble (0).
  - A digit with dp set is not blanked.
- enable=0:
  - an all 1, dp_out=1, frame_tick=0; prescaler and idx held at 0.
  - pending transfers to display on the next clock (no frame gating while dark).
  - On enable rising, scanning starts at digit 0 with a full slot.
- Reset mid-frame: immediate return to reset state. Pending data is lost.

Test Plan:
- Reset / basic scan (REFRESH_DIV=4, NUM_DIGITS=4): release rst_n with enable=1, load value=16'h1234, dp_in=0. After the first frame boundary:
  - an sequence is 1110,1101,1011,0111, each held for 4 cycles.
  - digit_out is 4,3,2,1 respectively.
  - frame_tick pulses every 16 cycles.
- Frame-gated update:
  - Load 16'hABCD mid-frame: pending=1, displayed digits are unchanged until the wrap. After the wrap, digit 0 shows D and pending=0.
  - Two loads within one frame (16'h1111 then 16'h2222): only 2222 appears.
- Leading-zero blanking: value=16'h0050, blank_lz=1.
  - Digits 3 and 2 have an all 1; digit 1 shows 5; digit 0 shows 0.
  - value=16'h0000: only digit 0 lit.
  - dp_in=4'b0100 with 16'h0050: digit 2 lit, showing 0 with dp_out=0.
- Enable gating: drop enable mid-slot. an=1111 on the next edge and frame_tick stays 0. Re-enable: an=1110 for a full 4 cycles.
- Async reset mid-operation: assert rst_n=0 between clock edges. an=1111, pending=0, digit_out=0 immediately, with no clock needed.
- Load at boundary: load 16'h5555 while pending holds 16'h4444, in the wrap cycle.
  - 4444 is displayed and pending stays 1.
  - 5555 is displayed at the next frame boundary.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//
// Time-multiplexed scan controller for a NUM_DIGITS common-anode 7-segment
// display. A prescaler divides clk into digit slots; an index walks the digits
// and one nibble per slot is presented to the external hex-to-segment decoder.
// New values are staged in a pending buffer and copied into the display
// registers only at a frame boundary (index wrap), so a frame never mixes old
// and new digits. While the scan is disabled the display is dark and a pending
// value is applied on the next clock.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   1 = scan running, 0 = display dark
//   load       in   strobe: capture value/dp_in into the pending buffer
//   value      in   4*NUM_DIGITS hex digits, nibble i = digit i (0 rightmost)
//   dp_in      in   decimal point per digit, 1 = lit
//   blank_lz   in   1 = suppress leading zeros
//   digit_out  out  nibble of the selected digit
//   an         out  anode enables, active low, at most one bit low
//   dp_out     out  decimal point, active low
//   frame_tick out  one-cycle pulse after the scan wraps to digit 0
//   pending    out  1 = loaded value not yet applied
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [3:0]              digit_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp_out,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int                IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Digit i (i>0) is blanked when every nibble from i upward is zero and
    // its own decimal point is off; digit 0 is always shown.
    function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(
        input logic [4*NUM_DIGITS-1:0] val,
        input logic [NUM_DIGITS-1:0]   dp,
        input logic                    blz
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (val[4*i +: 4] == 4'h0);
            mask[i]    = blz && zero_above && !dp[i];
        end
        return mask;
    endfunction

    logic [DIV_W-1:0]        presc_q,   presc_d;
    logic [IDX_W-1:0]        idx_q,     idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q,    disp_d;
    logic [NUM_DIGITS-1:0]   dpr_q,     dpr_d;
    logic [4*NUM_DIGITS-1:0] buf_val_q, buf_val_d;
    logic [NUM_DIGITS-1:0]   buf_dp_q,  buf_dp_d;
    logic                    pending_q, pending_d;
    logic [3:0]              digit_q,   digit_d;
    logic [NUM_DIGITS-1:0]   an_q,      an_d;
    logic                    dp_q,      dp_d;
    logic                    ft_q,      ft_d;

    logic                    slot_end_s;
    logic                    wrap_s;
    logic                    xfer_s;
    logic [NUM_DIGITS-1:0]   blank_mask_s;
    logic                    blank_s;

    // Slot/frame timing strobes and the pending-to-display transfer condition.
    always_comb begin
        slot_end_s = enable && (presc_q == DIV_LAST);
        wrap_s     = slot_end_s && (idx_q == IDX_LAST);
        // Dark display has no frame to protect, so transfer immediately.
        xfer_s     = pending_q && (wrap_s || !enable);
    end

    // Prescaler and digit index; both parked at 0 while disabled so a
    // re-enable starts at digit 0 with a full slot.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!enable) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (slot_end_s) begin
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            presc_d = presc_q + DIV_W'(1);
        end
    end

    // Double buffer: a transfer always moves the old buffer contents, while a
    // coincident load refills the buffer and keeps pending set.
    always_comb begin
        disp_d    = disp_q;
        dpr_d     = dpr_q;
        buf_val_d = buf_val_q;
        buf_dp_d  = buf_dp_q;
        pending_d = pending_q;
        if (xfer_s) begin
            disp_d    = buf_val_q;
            dpr_d     = buf_dp_q;
            pending_d = 1'b0;
        end else begin
            disp_d = disp_q;
        end
        if (load) begin
            buf_val_d = value;
            buf_dp_d  = dp_in;
            pending_d = 1'b1;
        end else begin
            buf_val_d = buf_val_q;
        end
    end

    // Output decode for the current index; registered so outputs lag idx by 1.
    always_comb begin
        blank_mask_s = lz_blank_mask(disp_q, dpr_q, blank_lz);
        blank_s      = blank_mask_s[idx_q];
        digit_d      = disp_q[{idx_q, 2'b00} +: 4];
        an_d         = '1;
        dp_d         = 1'b1;
        ft_d         = wrap_s;
        if (enable && !blank_s) begin
            an_d = ~(NUM_DIGITS'(1) << idx_q);
            dp_d = ~dpr_q[idx_q];
        end else begin
            an_d = '1;
            dp_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            dpr_q     <= '0;
            buf_val_q <= '0;
            buf_dp_q  <= '0;
            pending_q <= 1'b0;
            digit_q   <= 4'h0;
            an_q      <= '1;
            dp_q      <= 1'b1;
            ft_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            dpr_q     <= dpr_d;
            buf_val_q <= buf_val_d;
            buf_dp_q  <= buf_dp_d;
            pending_q <= pending_d;
            digit_q   <= digit_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
            ft_q      <= ft_d;
        end
    end

    assign digit_out  = digit_q;
    assign an         = an_q;
    assign dp_out     = dp_q;
    assign frame_tick = ft_q;
    assign pending    = pending_q;

endmodule
